// File: rtl/nbbpu_pkg.sv
// Shared NBBPU definitions: fetch FSM encoding, sticky fault codes, instruction width.
package nbbpu_pkg;

    localparam int INSTR_WIDTH = 16;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN = 2'b10;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_LO    = 2'd1,
        FETCH_HI    = 2'd2,
        FETCH_FAULT = 2'd3
    } fetch_state_t;

    // Little-endian pairing of two bus bytes into one instruction word.
    function automatic logic [INSTR_WIDTH-1:0] join_bytes(input logic [7:0] hi_byte,
                                                          input logic [7:0] lo_byte);
        return {hi_byte, lo_byte};
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating wait-cycle counter with clear/enable; expire flags the enabled cycle that
// would bring the count up to LIMIT, so the caller can act on that same edge.
module wait_timer #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WIDTH-1:0] MAX_COUNT  = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX_COUNT)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && !clear && (count >= LAST_COUNT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch for the NBBPU: reads a 16-bit instruction as two byte reads,
// caches the last fetched PC/instruction pair and stalls the core until it matches.
module fetch_unit
    import nbbpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  PC,
    input  logic                   mem_ready,
    input  logic [7:0]             mem_rdata,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic                   stall,
    output logic [1:0]             fault
);

    fetch_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] tag;
    logic                  tag_valid;
    logic [7:0]            lo_byte;

    logic       hit;
    logic       busy;
    logic       timer_expire;
    logic       latch_fetch;
    logic       take_lo;
    logic       take_hi;
    logic       set_fault;
    logic [1:0] fault_code;

    assign hit  = tag_valid && (tag == PC);
    assign busy = (state == FETCH_LO) || (state == FETCH_HI);

    // Timer restarts on every accepted byte so each byte gets its own budget.
    wait_timer #(
        .WIDTH(8),
        .LIMIT(TIMEOUT)
    ) u_wait_timer (
        .clock (clock),
        .reset (reset),
        .clear (!busy || mem_ready),
        .enable(busy && !mem_ready),
        .expire(timer_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        mem_addr    = '0;
        latch_fetch = 1'b0;
        take_lo     = 1'b0;
        take_hi     = 1'b0;
        set_fault   = 1'b0;
        fault_code  = FAULT_NONE;
        case (state)
            FETCH_IDLE: begin
                if (!hit) begin
                    if (PC[0]) begin
                        state_next = FETCH_FAULT;
                        set_fault  = 1'b1;
                        fault_code = FAULT_MISALIGN;
                    end else begin
                        state_next  = FETCH_LO;
                        latch_fetch = 1'b1;
                    end
                end
            end
            FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = {fetch_addr[ADDR_WIDTH-1:1], 1'b0};
                if (mem_ready) begin
                    state_next = FETCH_HI;
                    take_lo    = 1'b1;
                end else if (timer_expire) begin
                    state_next = FETCH_FAULT;
                    set_fault  = 1'b1;
                    fault_code = FAULT_TIMEOUT;
                end
            end
            FETCH_HI: begin
                mem_req  = 1'b1;
                mem_addr = {fetch_addr[ADDR_WIDTH-1:1], 1'b1};
                if (mem_ready) begin
                    state_next = FETCH_IDLE;
                    take_hi    = 1'b1;
                end else if (timer_expire) begin
                    state_next = FETCH_FAULT;
                    set_fault  = 1'b1;
                    fault_code = FAULT_TIMEOUT;
                end
            end
            FETCH_FAULT: begin
                state_next = FETCH_FAULT;
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    // A PC change mid-fetch does not abort the bus pair; the tag records what was
    // actually fetched, so IDLE simply sees a miss afterwards and refetches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_addr  <= '0;
            tag         <= '0;
            tag_valid   <= 1'b0;
            lo_byte     <= '0;
            instruction <= '0;
            fault       <= FAULT_NONE;
        end else begin
            if (latch_fetch) begin
                fetch_addr <= PC;
            end
            if (take_lo) begin
                lo_byte <= mem_rdata;
            end
            if (take_hi) begin
                instruction <= join_bytes(mem_rdata, lo_byte);
                tag         <= fetch_addr;
                tag_valid   <= 1'b1;
            end
            if (set_fault) begin
                fault <= fault_code;
            end
        end
    end

    assign instr_valid = (state == FETCH_IDLE) && hit && (fault == FAULT_NONE);
    assign stall       = ~instr_valid;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the NBBPU datapath.
- Takes the datapath's byte-addressed PC and fetches the 16-bit instruction at that address over a byte-wide, variable-latency memory handshake.
- Presents the assembled instruction to the datapath's instruction input, plus a stall that gates the core's PC register and register-file writes.
- Holds the last fetched instruction, so an unchanged PC costs no further bus traffic.

Parameters:
- ADDR_WIDTH, 16, width of PC and memory address.
- TIMEOUT, 255, max cycles waiting for mem_ready on one byte before fault; legal range 1..255.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- PC  input  ADDR_WIDTH  current program counter from the datapath (byte address)
- mem_ready  input  1  memory has valid byte on mem_rdata this cycle
- mem_rdata  input  8  memory read byte
- mem_req  output  1  read request; held with stable mem_addr until accepted
- mem_addr  output  ADDR_WIDTH  byte address being read
- instruction  output  16  fetched instruction to the datapath
- instr_valid  output  1  instruction corresponds to the current PC
- stall  output  1  equals ~instr_valid; core must not advance PC or commit results
- fault  output  2  sticky fault code: 00 none, 01 timeout, 10 misaligned

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-high.
- Reset values: state IDLE, tag_valid 0, tag 0, mem_req 0, mem_addr 0, instruction 0x0000, instr_valid 0, stall 1, fault 00, timer 0.
- Registered state: tag (ADDR_WIDTH), tag_valid, lo_byte (8), instruction (16), fault.
- instr_valid = (state==IDLE) && tag_valid && (tag==PC) && (fault==00). This output is combinational from PC.
- States: IDLE, LO, HI, FAULT.
- IDLE:
  - Hit (tag_valid and tag==PC): stay in IDLE, mem_req 0.
  - Miss with PC[0]==1: go to FAULT, fault<=10.
  - Miss otherwise: latch fetch_addr<=PC and go to LO.
- LO:
  - mem_req=1, mem_addr=fetch_addr (bit0=0).
  - On mem_ready: lo_byte<=mem_rdata, timer cleared, go to HI.
- HI:
  - mem_req=1, mem_addr={fetch_addr[ADDR_WIDTH-1:1],1'b1}.
  - On mem_ready: instruction<={mem_rdata,lo_byte} (little-endian), tag<=fetch_addr, tag_valid<=1, go to IDLE.
- Latency: with zero-wait memory (mem_ready high whenever mem_req is high), instr_valid rises exactly 3 cycles after the IDLE cycle that saw the miss. Each wait cycle adds 1.
- Timeout:
  - The timer increments each LO/HI cycle without mem_ready.
  - When the timer reaches TIMEOUT with no mem_ready, go to FAULT, fault<=01, mem_req drops next cycle.
  - A mem_ready arriving in the same cycle as the timer reaching TIMEOUT wins; no fault is raised.
- FAULT:
  - mem_req 0, instr_valid 0, stall 1.
  - fault is held and the state is left only by reset.
- PC change mid-fetch:
  - The bus transaction is never aborted; both bytes complete and the tag is written with fetch_addr.
  - Back in IDLE, the tag then mismatches and a new fetch starts the following cycle.
- Address wrap: PC=0xFFFE fetches 0xFFFE/0xFFFF; no carry logic is needed.
- Reset asserted mid-fetch: mem_req drops immediately (asynchronously) and everything returns to reset values. The memory must tolerate an abandoned request.
- Hit path: no mem_req ever asserted while PC equals a valid tag.

Decomposition:
- Shared package nbbpu_pkg holds:
  - the fetch state encoding (IDLE, LO, HI, FAULT);
  - fault codes FAULT_NONE=2'b00, FAULT_TIMEOUT=2'b01, FAULT_MISALIGN=2'b10;
  - INSTR_WIDTH=16.
- One sub-module, wait_timer: a saturating counter with clear, enable and a TIMEOUT compare output. It is reusable by the future data-memory interface.

Test Plan:
- Reset: during and after reset, mem_req=0, instruction=0x0000, instr_valid=0, stall=1, fault=00.
- Zero-wait fetch: PC=0x0010, memory returns 0x34 at 0x0010 and 0x12 at 0x0011 -> mem_addr sequence 0x0010, 0x0011; instruction=0x1234 and instr_valid=1 three cycles after the miss. Holding PC, no further mem_req for 20 cycles.
- Wait states: PC=0x0100, mem_ready delayed 2 cycles per byte, bytes 0xCD/0xAB -> mem_addr stable while waiting; instruction=0xABCD with instr_valid 7 cycles after the miss.
- Timeout and misalignment:
  - TIMEOUT=8, PC=0x0020, mem_ready never asserted -> fault=01 after 8 LO cycles; mem_req=0 and stall=1 thereafter until reset.
  - Separately, PC=0x0003 -> fault=10 with no mem_req ever asserted.
- PC change mid-fetch: PC=0x0040, changed to 0x0042 during HI -> the 0x0040 transaction completes; then a new fetch at 0x0042/0x0043; instr_valid only with 0x0042's instruction.
- Reset mid-fetch: reset asserted during LO with mem_req=1 -> mem_req=0 in the same cycle (async); after release, the same PC is refetched from LO.
